// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction-fetch stage. It keeps a fetch PC and issues word
//            requests to instruction memory. Returned words go into a
//            one-entry output buffer that feeds the decode register.
//            A three-state controller (IDLE / PEND / DRAIN) handles
//            multi-cycle memory latency. It also handles a redirect that
//            arrives while a request is still outstanding.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          in   1   clock, all state updates on the rising edge
//   rst_i          in   1   synchronous reset, active low
//   stall_i        in   1   decode register holding; buffered instr kept
//   redirect_i     in   1   taken branch/jump, flushes the buffer
//   redirect_pc_i  in  32   redirect target (low two bits ignored)
//   imem_req_o     out  1   instruction memory request
//   imem_addr_o    out 32   request address, always word aligned
//   imem_ack_i     in   1   memory returns data in this cycle
//   imem_rdata_i   in  32   instruction word, valid with req && ack
//   pc_o           out 32   PC of the buffered instruction
//   instr_o        out 32   buffered instruction word
//   valid_o        out  1   buffer holds a live instruction
// ============================================================================
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  // IDLE : no request outstanding; a request is issued whenever the buffer
  //        can take the result.
  // PEND : a request was not acknowledged. It is held at its address until
  //        the ack arrives. Its data is then captured.
  // DRAIN: a redirect arrived while a request was outstanding. The memory
  //        still owes an ack for the old address. The request is held until
  //        that ack arrives, and the returned word is thrown away.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] C_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] C_RESET_PC   = RESET_PC & C_ALIGN_MASK;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;      // next address to fetch
  logic [31:0] addr_q, addr_d;    // address of an outstanding request
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  logic        w_consume;
  logic        w_free;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_capture;

  // --------------------------------------------------------------------------
  // Request generation and next-state computation
  // --------------------------------------------------------------------------
  always_comb begin
    // Decode takes the buffered instruction only when it is neither stalled
    // nor being flushed by a redirect.
    w_consume = valid_q && !stall_i && !redirect_i;
    // The buffer can accept a new word if it is empty now or drains this cycle.
    w_free    = !valid_q || w_consume;

    w_req  = 1'b0;
    w_addr = fpc_q;
    unique case (state_q)
      ST_IDLE: begin
        // A redirect suppresses the request. The fetch PC is stale in that cycle.
        w_req  = w_free && !redirect_i;
        w_addr = fpc_q;
      end
      ST_PEND, ST_DRAIN: begin
        // An outstanding request must stay stable until it is acknowledged.
        w_req  = 1'b1;
        w_addr = addr_q;
      end
      default: begin
        w_req  = 1'b0;
        w_addr = fpc_q;
      end
    endcase

    // Memory is reset together with this stage, so an outstanding request
    // is abandoned while reset is held.
    if (!rst_i) begin
      w_req = 1'b0;
    end

    // Acked data is kept only if the fetch is still wanted. Data is dropped
    // in DRAIN, and also in any cycle where a redirect arrives.
    w_capture = w_req && imem_ack_i && !redirect_i && (state_q != ST_DRAIN);

    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (w_req && !imem_ack_i) begin
          state_d = ST_PEND;
          addr_d  = fpc_q;
        end
      end
      ST_PEND: begin
        if (imem_ack_i) begin
          state_d = ST_IDLE;
        end else if (redirect_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The fetch PC follows the redirect target. Otherwise it advances past
    // each captured word. The 32-bit add wraps naturally at the top.
    if (redirect_i) begin
      fpc_d = redirect_pc_i & C_ALIGN_MASK;
    end else if (w_capture) begin
      fpc_d = w_addr + 32'd4;
    end

    // Buffer priority: redirect flush, then capture, then plain consume.
    if (redirect_i) begin
      valid_d = 1'b0;
      pc_d    = 32'd0;
      instr_d = 32'd0;
    end else if (w_capture) begin
      valid_d = 1'b1;
      pc_d    = w_addr;
      instr_d = imem_rdata_i;
    end else if (w_consume) begin
      valid_d = 1'b0;
      pc_d    = 32'd0;
      instr_d = 32'd0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      fpc_q   <= C_RESET_PC;
      addr_q  <= C_RESET_PC;
      valid_q <= 1'b0;
      pc_q    <= 32'd0;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req_o  = w_req;
  assign imem_addr_o = w_addr;
  assign valid_o     = valid_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;

endmodule
`default_nettype wire

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-low.
REQ-004 stall_i  input  1  downstream fetch/decode register holding; buffered instruction not consumed.
REQ-005 redirect_i  input  1  taken branch/jump; asserted in the same cycle as the decode-register flush.
REQ-006 redirect_pc_i  input  32  redirect target.
REQ-007 imem_req_o  output  1  instruction memory request.
REQ-008 imem_addr_o  output  32  request address, word aligned.
REQ-009 imem_ack_i  input  1  memory accepts request and returns data this cycle; may be high the same cycle req first rises.
REQ-010 imem_rdata_i  input  32  instruction word, valid when imem_req_o && imem_ack_i.
REQ-011 pc_o  output  32  PC of buffered instruction, feeds decode register pc input.
REQ-012 instr_o  output  32  buffered instruction, feeds decode register instr input.
REQ-013 valid_o  output  1  pc_o/instr_o hold a live instruction; low means the top inserts a bubble.

Function
REQ-014 Internal fetch PC fpc; one-entry output buffer {valid_o, pc_o, instr_o}; FSM states IDLE, PEND, DRAIN.
REQ-015 consume = valid_o && ~stall_i && ~redirect_i; buffer is free when ~valid_o || consume.
REQ-016 IDLE: imem_req_o = free && ~redirect_i; imem_addr_o = fpc.
REQ-017 IDLE, req && ack: buffer <= {1, fpc, imem_rdata_i}; fpc <= fpc+4; stay IDLE (1 instr/cycle with zero-wait memory).
REQ-018 IDLE, req && ~ack: -> PEND, address latched.
REQ-019 PEND: imem_req_o=1, imem_addr_o held stable until ack; on ack capture as REQ-017, -> IDLE.
REQ-020 Buffer cannot be valid while PEND (request only issued when free); no overflow path exists.
REQ-021 Consume without capture in the same cycle: valid_o <= 0, pc_o <= 0, instr_o <= 0.
REQ-022 stall_i with valid_o=1 and no redirect: buffer unchanged, no new request.
REQ-023 redirect_i has priority over stall_i and capture: fpc <= {redirect_pc_i[31:2],2'b00}; buffer cleared to 0; any ack data that cycle discarded.
REQ-024 redirect_i in IDLE: no request that cycle; stay IDLE.
REQ-025 redirect_i in PEND without ack: -> DRAIN; request held at old address (never abandoned).
REQ-026 redirect_i in PEND with ack: data dropped, -> IDLE.
REQ-027 DRAIN: imem_req_o=1 at old address; on ack data discarded, -> IDLE; buffer stays empty.
REQ-028 redirect_i in DRAIN: fpc updated again; remain DRAIN until ack.
REQ-029 fpc increments mod 2^32; wrap 32'hFFFF_FFFC -> 32'h0000_0000 with no special handling.
REQ-030 imem_addr_o[1:0] always 2'b00.

Reset
REQ-031 When rst_i=0 at a clock edge: state <= IDLE, fpc <= RESET_PC, valid_o/pc_o/instr_o <= 0.
REQ-032 While rst_i=0, imem_req_o=0; a PEND/DRAIN request is abandoned by reset (memory is reset together).
REQ-033 First request issued in the first cycle with rst_i=1, address RESET_PC.

Verification
REQ-034 Zero-wait ack constant, stall_i=0 after reset -> valid_o high from cycle 2, pc_o 0,4,8,... one per cycle, instr_o = memory words.
REQ-035 Ack delayed 3 cycles -> imem_req_o/addr stable 4 cycles, valid_o pulses one cycle per fetch, PCs in order.
REQ-036 stall_i high 5 cycles with valid_o=1, pc_o=0x10 -> pc_o/instr_o held, no imem_req_o; release -> 0x14 next.
REQ-037 redirect_i to 0x100 while PEND (ack 2 cycles later) -> DRAIN, old addr held, its data never on instr_o; next request 0x100, then pc_o=0x100.
REQ-038 redirect_i with stall_i high and redirect_pc_i=0x203 -> buffer cleared, next fetch address 0x200.
REQ-039 rst_i low mid-PEND -> next cycle imem_req_o=0, valid_o=0; on release request at RESET_PC.
